// File: rtl/hilo_muldiv_ctrl_if.sv
// rtl/hilo_muldiv_ctrl_if.sv - request/result bundle between EX stage and HI/LO mul/div sequencer
interface hilo_muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             cancel;
    logic             busy;
    logic             hiWtCe;
    logic             loWtCe;
    logic [WIDTH-1:0] hiWtData;
    logic [WIDTH-1:0] loWtData;
    logic             divZero;

    // EX-stage side: issues requests and flushes, consumes stall and write port
    modport master (
        output start, op, opA, opB, cancel,
        input  busy, hiWtCe, loWtCe, hiWtData, loWtData, divZero
    );

    // Sequencer side
    modport slave (
        input  start, op, opA, opB, cancel,
        output busy, hiWtCe, loWtCe, hiWtData, loWtData, divZero
    );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - multi-cycle shift-add multiplier / restoring divider owning HI/LO writes
module hilo_muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    hilo_muldiv_ctrl_if.slave    bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Counter value meaning "all iterations done, apply sign fix-up on this edge"
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic             is_div;
    logic             is_dz;
    logic             neg_p;    // negate product / quotient
    logic             neg_r;    // negate remainder (dividend was negative)
    logic [WIDTH-1:0] mc;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0] p_hi;     // product high half or partial remainder
    logic [WIDTH-1:0] p_lo;     // multiplier bits / quotient bits
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] hold_hi;
    logic [WIDTH-1:0] hold_lo;

    // Operand magnitudes; an unsigned W-bit magnitude already covers the most-negative value
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    // Per-iteration datapath
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;

    // Final results with signs applied
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;

    logic             wr;

    // Operand sign decode and magnitudes (signed ops have op[0]=1)
    always_comb begin
        a_neg = bus.op[0] & bus.opA[WIDTH-1];
        b_neg = bus.op[0] & bus.opB[WIDTH-1];
        mag_a = a_neg ? (~bus.opA + 1'b1) : bus.opA;
        mag_b = b_neg ? (~bus.opB + 1'b1) : bus.opB;
    end

    // One shift-add step and one restoring-divide step, selected by state
    always_comb begin
        mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mc} : '0);
        div_shift = {p_hi, p_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mc};
        div_ge    = ~div_diff[WIDTH];
    end

    // Sign fix-up and result selection, consumed on the edge entering DONE
    always_comb begin
        prod     = {p_hi, p_lo};
        prod_fix = neg_p ? (~prod + 1'b1) : prod;
        q_fix    = neg_p ? (~p_lo + 1'b1) : p_lo;
        r_fix    = neg_r ? (~p_hi + 1'b1) : p_hi;
        if (is_dz) begin
            fin_hi = p_hi;
            fin_lo = '1;
        end else if (is_div) begin
            fin_hi = r_fix;
            fin_lo = q_fix;
        end else begin
            fin_hi = prod_fix[2*WIDTH-1:WIDTH];
            fin_lo = prod_fix[WIDTH-1:0];
        end
    end

    // Write port: pulse only in DONE, killed by a same-cycle flush; data holds otherwise
    always_comb begin
        wr           = (state == S_DONE) && !bus.cancel;
        bus.hiWtCe   = wr;
        bus.loWtCe   = wr;
        bus.divZero  = wr && is_dz;
        bus.hiWtData = wr ? res_hi : hold_hi;
        bus.loWtData = wr ? res_lo : hold_lo;
        bus.busy     = busy_q;
    end

    // Sequencer FSM and iteration registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            busy_q  <= 1'b0;
            is_div  <= 1'b0;
            is_dz   <= 1'b0;
            neg_p   <= 1'b0;
            neg_r   <= 1'b0;
            mc      <= '0;
            p_hi    <= '0;
            p_lo    <= '0;
            res_hi  <= '0;
            res_lo  <= '0;
            hold_hi <= '0;
            hold_lo <= '0;
        end else if (bus.cancel) begin
            state  <= S_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        is_div <= bus.op[1];
                        neg_p  <= a_neg ^ b_neg;
                        neg_r  <= bus.op[1] & a_neg;
                        mc     <= bus.op[1] ? mag_b : mag_a;
                        p_lo   <= bus.op[1] ? mag_a : mag_b;
                        if (bus.op[1] && (bus.opB == '0)) begin
                            // Skip iterations: next edge finishes with raw dividend in HI
                            is_dz <= 1'b1;
                            p_hi  <= bus.opA;
                            cnt   <= CNT_LAST;
                            state <= S_DIV;
                        end else begin
                            is_dz <= 1'b0;
                            p_hi  <= '0;
                            cnt   <= '0;
                            state <= bus.op[1] ? S_DIV : S_MUL;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (cnt == CNT_LAST) begin
                        res_hi <= fin_hi;
                        res_lo <= fin_lo;
                        busy_q <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (state == S_MUL) begin
                            p_hi <= mul_sum[WIDTH:1];
                            p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
                        end else begin
                            p_hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                            p_lo <= {p_lo[WIDTH-2:0], div_ge};
                        end
                    end
                end
                default: begin
                    hold_hi <= res_hi;
                    hold_lo <= res_lo;
                    state   <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb/tb_hilo_muldiv_ctrl.sv - directed self-checking bench for hilo_muldiv_ctrl
module tb_hilo_muldiv_ctrl;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   wr_cnt;

    logic [W-1:0] cap_hi;
    logic [W-1:0] cap_lo;
    logic         cap_dz;
    logic         cap_lo_ce;

    hilo_muldiv_ctrl_if #(.WIDTH(W)) bus ();

    hilo_muldiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.hiWtCe) wr_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit noise, output int lat, output int bc);
        @(negedge clk);
        bus.op    = o;
        bus.opA   = a;
        bus.opB   = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = -1;
        bc  = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (bus.hiWtCe) begin
                lat       = i - 1;
                cap_hi    = bus.hiWtData;
                cap_lo    = bus.loWtData;
                cap_dz    = bus.divZero;
                cap_lo_ce = bus.loWtCe;
                bus.start = 1'b0;
                break;
            end
            if (bus.busy) bc++;
            bus.start = noise && (i == 5 || i == 10);
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit noise, input logic [W-1:0] exp_hi,
                         input logic [W-1:0] exp_lo, input logic exp_dz, input int exp_lat);
        int lat;
        int bc;
        int w0;
        w0 = wr_cnt;
        run_op(o, a, b, noise, lat, bc);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy"}, 64'(bc), 64'(exp_lat));
        check({tag, "_hi"}, 64'(cap_hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(cap_lo), 64'(exp_lo));
        check({tag, "_dz"}, 64'(cap_dz), 64'(exp_dz));
        check({tag, "_loce"}, 64'(cap_lo_ce), 64'(1));
        repeat (3) @(negedge clk);
        check({tag, "_one_pulse"}, 64'(wr_cnt - w0), 64'(1));
        check({tag, "_hold_hi"}, 64'(bus.hiWtData), 64'(exp_hi));
        check({tag, "_hold_lo"}, 64'(bus.loWtData), 64'(exp_lo));
    endtask

    initial begin
        int w0;
        n_checks   = 0;
        n_fail     = 0;
        wr_cnt     = 0;
        rst        = 1'b0;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.op     = 2'b00;
        bus.opA    = '0;
        bus.opB    = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_hice", 64'(bus.hiWtCe), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        check("rst_hidata", 64'(bus.hiWtData), 64'(0));
        check("rst_lodata", 64'(bus.loWtData), 64'(0));
        check("rst_dz", 64'(bus.divZero), 64'(0));
        check("rst_no_wr", 64'(wr_cnt), 64'(0));

        do_op("t1_multu", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
        do_op("t2_mult", 2'b01, 32'hFFFFFFFD, 32'd5, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33);
        do_op("t3_div", 2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
        do_op("t3_divu", 2'b10, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0, 33);
        do_op("div_pos_neg", 2'b11, 32'd7, 32'hFFFFFFFE, 1'b0, 32'd1, 32'hFFFFFFFD, 1'b0, 33);
        do_op("div_minneg", 2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h80000000, 1'b0, 33);
        do_op("mult_minneg", 2'b01, 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h0, 1'b0, 33);
        do_op("t4_divzero", 2'b10, 32'h1234, 32'h0, 1'b0, 32'h1234, 32'hFFFFFFFF, 1'b1, 1);

        // T5: flush mid-multiply, then a clean op with stray starts while busy
        w0 = wr_cnt;
        @(negedge clk);
        bus.op = 2'b01; bus.opA = 32'd6; bus.opB = 32'hFFFFFFF9; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.cancel = 1'b1;
        @(posedge clk);
        #1 bus.cancel = 1'b0;
        check("t5_cancel_busy", 64'(bus.busy), 64'(1'b0));
        repeat (40) @(negedge clk);
        check("t5_cancel_no_wr", 64'(wr_cnt - w0), 64'(0));
        check("t5_cancel_hold", 64'(bus.hiWtData), 64'(32'h1234));
        do_op("t5_after", 2'b01, 32'd6, 32'hFFFFFFF9, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 33);

        // start and cancel together in IDLE: request dropped
        w0 = wr_cnt;
        @(negedge clk);
        bus.op = 2'b10; bus.opA = 32'd9; bus.opB = 32'd0; bus.start = 1'b1; bus.cancel = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0; bus.cancel = 1'b0;
        check("start_cancel_busy", 64'(bus.busy), 64'(0));
        repeat (4) @(negedge clk);
        check("start_cancel_no_wr", 64'(wr_cnt - w0), 64'(0));

        // cancel landing in DONE suppresses the write combinationally
        w0 = wr_cnt;
        @(negedge clk);
        bus.op = 2'b10; bus.opA = 32'h55; bus.opB = 32'd0; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #1 bus.cancel = 1'b1;
        #1 check("done_cancel_hice", 64'(bus.hiWtCe), 64'(0));
        check("done_cancel_dz", 64'(bus.divZero), 64'(0));
        check("done_cancel_hold", 64'(bus.loWtData), 64'(32'hFFFFFFD6));
        @(posedge clk);
        #1 bus.cancel = 1'b0;
        repeat (3) @(negedge clk);
        check("done_cancel_no_wr", 64'(wr_cnt - w0), 64'(0));

        // T6: asynchronous reset in the middle of a divide
        w0 = wr_cnt;
        @(negedge clk);
        bus.op = 2'b11; bus.opA = 32'd1000; bus.opB = 32'd3; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #3 rst = 1'b0;
        #1 check("t6_busy", 64'(bus.busy), 64'(0));
        check("t6_hice", 64'(bus.hiWtCe), 64'(0));
        check("t6_loce", 64'(bus.loWtCe), 64'(0));
        check("t6_hidata", 64'(bus.hiWtData), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("t6_no_wr", 64'(wr_cnt - w0), 64'(0));
        do_op("t6_after", 2'b10, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
